// File: rtl/encipher_seq.sv
// rtl/encipher_seq.sv - Iterative AES forward cipher, one round per enabled clock.
// Round primitives are split into small modules so each appears once in the datapath.

module subBytes (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (e[i]) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        dout = '0;
        for (int n = 0; n < 16; n++) begin
            dout[127-8*n -: 8] = sbox(din[127-8*n -: 8]);
        end
    end
endmodule

module shiftRows (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
    always_comb begin
        dout = '0;
        for (int n = 0; n < 16; n++) begin
            dout[127-8*n -: 8] = din[127-8*((n % 4) + 4*(((n / 4) + (n % 4)) % 4)) -: 8];
        end
    end
endmodule

module mixColumns (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        dout = '0;
        for (int c = 0; c < 4; c++) begin
            dout[127-32*c -: 32] = mix_col(din[127-32*c -: 32]);
        end
    end
endmodule

module addRoundKey (
    input  logic [127:0] din,
    input  logic [127:0] key,
    output logic [127:0] dout
);
    assign dout = din ^ key;
endmodule

module encipher_seq #(
    parameter int Nk = 4,
    parameter int Nr = 10,
    parameter int KW = 128*(Nr+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in,
    input  logic [KW-1:0] word,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out,
    output logic          busy
);
    if (Nr != Nk + 6) begin : g_bad_cfg
        $error("encipher_seq: Nr must equal Nk+6");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [3:0] NR4 = 4'(Nr);

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic [127:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;

    logic         last;
    logic [127:0] rk;
    logic [127:0] sb_out, sr_out, mc_out, ark_in, ark_out;

    assign last = (round_q == NR4);
    // round_q is 0 in IDLE, so the same select yields rk[0] for the initial whitening.
    assign rk   = word[128*round_q +: 128];

    subBytes    u_sub (.din(state_q), .dout(sb_out));
    shiftRows   u_shr (.din(sb_out),  .dout(sr_out));
    mixColumns  u_mix (.din(sr_out),  .dout(mc_out));

    always_comb begin
        ark_in = mc_out;
        if (fsm_q == IDLE) ark_in = in;
        else if (last)     ark_in = sr_out;
    end

    addRoundKey u_ark (.din(ark_in), .key(rk), .dout(ark_out));

    always_comb begin
        fsm_d       = fsm_q;
        round_d     = round_q;
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (en) begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = ark_out;
                        round_d = 4'd1;
                        fsm_d   = ROUND;
                    end
                end
                ROUND: begin
                    if (!last) begin
                        state_d = ark_out;
                        round_d = round_q + 4'd1;
                    end else begin
                        out_d       = ark_out;
                        out_valid_d = 1'b1;
                        fsm_d       = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        round_d     = 4'd0;
                        fsm_d       = IDLE;
                    end
                end
                default: begin
                    fsm_d   = IDLE;
                    round_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            round_q     <= 4'd0;
            state_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;
endmodule
